pll_reconfig_ctrl: RTL and testbench
====================================

# pll_reconfig_ctrl

Sequencer for the GW1NSR-4C PLLVR in dynamic-divider mode. It owns the PLL's RESET and IDSEL/FBDSEL/ODSEL pins and brings the PLL up at power-on. It accepts divider-change requests through a valid/ready handshake, waits for a qualified, debounced LOCK, and retries on timeout. It runs on the 27 MHz board oscillator, never on a PLL output, and flags downstream logic through `pll_ok`.

## Interface
Parameters:
- `RST_CYCLES`, 16: PLL RESET pulse width in sys_clk cycles (≥2).
- `LOCK_STABLE`, 1024: consecutive cycles synced LOCK must stay high to qualify.
- `LOCK_TIMEOUT`, 65535: cycles after RESET release before an attempt fails.
- `MAX_RETRY`, 3: attempts per request before entering ERROR (≥1).
- `DEF_IDSEL` / `DEF_FBDSEL` / `DEF_ODSEL`, 6'd0 each: power-on divider codes.

Ports (one clock; reset is synchronous and active-low):
- `sys_clk` input 1: 27 MHz oscillator clock.
- `sys_rst_n` input 1: synchronous reset, active low.
- `req_valid` input 1: request carries new divider codes.
- `req_ready` output 1: controller can accept a request.
- `req_idsel` / `req_fbdsel` / `req_odsel` input 6 each: raw PLLVR select codes, passed through uninterpreted.
- `pll_lock` input 1: PLLVR LOCK, asynchronous to sys_clk.
- `pll_reset` output 1: drives PLLVR RESET.
- `pll_idsel` / `pll_fbdsel` / `pll_odsel` output 6 each: drive PLLVR IDSEL/FBDSEL/ODSEL.
- `pll_ok` output 1: PLL locked and qualified; the PLL clock is usable.
- `busy` output 1: a sequence is in progress.
- `done` output 1: one-cycle pulse when an attempt qualifies lock.
- `err` output 1: sticky failure flag.
- `lock_lost` output 1: one-cycle pulse when qualified lock drops.

## Operation
- LOCK passes through a 2-flop synchronizer to produce `lock_s`. All decisions use `lock_s`.
- States: RST_PLL, WAIT_LOCK, IDLE, ERROR.
- RST_PLL:
  - `pll_reset`=1 for exactly RST_CYCLES cycles, then move to WAIT_LOCK.
  - Select outputs are already stable on entry.
- WAIT_LOCK:
  - `pll_reset`=0. A timeout counter and a stable counter run.
  - `lock_s`=0 clears the stable counter.
  - Stable counter reaching LOCK_STABLE: go to IDLE, `done` pulse, clear retry count.
  - Timeout counter reaching LOCK_TIMEOUT first: retry count +1. If the count is below MAX_RETRY, return to RST_PLL with the same codes. Otherwise go to ERROR.
- IDLE:
  - `pll_ok`=1.
  - `lock_s`=0: `lock_lost` pulse, `pll_ok`=0, go to RST_PLL with the current codes and a fresh retry count.
- ERROR:
  - `pll_reset` held 1, `err`=1, `pll_ok`=0.
  - Only an accepted request leaves this state.
- `req_ready` = (IDLE && `lock_s`) || ERROR. It is combinational from state and `lock_s`.
- Accept on `req_valid && req_ready`:
  - Register the three codes into the select outputs.
  - Clear `err` and the retry count.
  - Go to RST_PLL.
- `busy` = RST_PLL || WAIT_LOCK.
- Counters saturate and never wrap. Widths are sized by $clog2 of each parameter.

## Timing
- Values while `sys_rst_n`=0, and on the first cycle after release:
  - state RST_PLL, `pll_reset`=1.
  - Select outputs = DEF_*.
  - `pll_ok`=0, `done`=0, `err`=0, `lock_lost`=0, `busy`=1, `req_ready`=0.
  - All counters 0.
- Power-on runs the full sequence with the defaults. No request is needed.
- Request accepted at edge T:
  - New codes and `pll_reset`=1 visible after T.
  - `pll_reset` falls after T+RST_CYCLES.
  - `pll_ok`=0 from after T.
- Minimum latency from RESET release to `done` = LOCK_STABLE+2 cycles: 2 synchronizer cycles plus the stable count.
- `done` and `pll_ok` rise in the same cycle.
- Selects change only at acceptance or reset. They never change while `pll_reset`=0.
- LOCK falls in the same cycle `req_valid` is high in IDLE: `req_ready` is already 0, so the request is not accepted. The lock-loss path runs; the requester must hold `req_valid`.
- `sys_rst_n` low mid-sequence: the next edge restores reset values and power-on restarts with DEF_* codes. Any pending request is dropped.
- LOCK glitch shorter than LOCK_STABLE during WAIT_LOCK: restarts qualification only. The timeout counter keeps running.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=50, MAX_RETRY=2.
- Power-on, LOCK rises 10 cycles after `pll_reset` falls:
  - `pll_reset` high exactly 4 cycles after reset release.
  - `done` and `pll_ok` assert at release+4+10+2+8.
  - Selects = DEF_*.
- In IDLE, request codes 8/52/4:
  - `req_ready` drops next cycle and selects = 8/52/4.
  - `pll_reset` high 4 cycles; `done` after re-lock.
- LOCK never rises:
  - Two RESET pulses, each followed by a 50-cycle wait.
  - Then `err`=1, `pll_reset` stuck 1, `req_ready`=1.
  - A new request clears `err`.
- LOCK toggles with a period of 6 cycles during WAIT_LOCK:
  - No `done`; timeout and retry occur.
  - Once LOCK is held, `done` follows 10 cycles after the rise.
- LOCK drops in IDLE while `req_valid`=1:
  - `lock_lost` pulses and the request is not accepted.
  - Relock runs with the old codes, then the held request is accepted.
- `sys_rst_n` pulsed low mid-WAIT_LOCK: outputs return to reset values and selects return to DEF_*.

Source files
------------

// File: rtl/pll_reconfig_ctrl.sv
// PLLVR bring-up and divider-change sequencer clocked from the board oscillator.
// Owns PLL RESET and select codes, qualifies synchronized LOCK, retries on timeout.
module pll_reconfig_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [5:0]  DEF_IDSEL    = 6'd0,
  parameter logic [5:0]  DEF_FBDSEL   = 6'd0,
  parameter logic [5:0]  DEF_ODSEL    = 6'd0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_idsel,
  input  logic [5:0] req_fbdsel,
  input  logic [5:0] req_odsel,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       pll_ok,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       lock_lost
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned NW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    ST_RST_PLL,
    ST_WAIT_LOCK,
    ST_IDLE,
    ST_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic          lock_meta_q, lock_meta_d;
  logic          lock_s_q, lock_s_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [NW-1:0] retry_q, retry_d;
  logic [NW-1:0] retry_inc;
  logic [5:0]    idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
  logic          pll_reset_q, pll_reset_d;
  logic          pll_ok_q, pll_ok_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          lock_lost_q, lock_lost_d;
  logic          accept;

  assign req_ready  = ((state_q == ST_IDLE) && lock_s_q) || (state_q == ST_ERROR);
  assign busy       = (state_q == ST_RST_PLL) || (state_q == ST_WAIT_LOCK);
  assign accept     = req_valid && req_ready;
  assign retry_inc  = retry_q + NW'(1);

  assign pll_reset  = pll_reset_q;
  assign pll_idsel  = idsel_q;
  assign pll_fbdsel = fbdsel_q;
  assign pll_odsel  = odsel_q;
  assign pll_ok     = pll_ok_q;
  assign done       = done_q;
  assign err        = err_q;
  assign lock_lost  = lock_lost_q;

  always_comb begin
    lock_meta_d  = pll_lock;
    lock_s_d     = lock_meta_q;
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    stable_cnt_d = stable_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    retry_d      = retry_q;
    idsel_d      = idsel_q;
    fbdsel_d     = fbdsel_q;
    odsel_d      = odsel_q;
    pll_reset_d  = pll_reset_q;
    pll_ok_d     = pll_ok_q;
    done_d       = 1'b0;
    err_d        = err_q;
    lock_lost_d  = 1'b0;

    unique case (state_q)
      ST_RST_PLL: begin
        pll_reset_d = 1'b1;
        pll_ok_d    = 1'b0;
        if (rst_cnt_q >= RW'(RST_CYCLES - 1)) begin
          state_d      = ST_WAIT_LOCK;
          pll_reset_d  = 1'b0;
          rst_cnt_d    = '0;
          stable_cnt_d = '0;
          tmo_cnt_d    = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        pll_reset_d = 1'b0;
        if (!lock_s_q)
          stable_cnt_d = '0;
        else if (stable_cnt_q != SW'(LOCK_STABLE))
          stable_cnt_d = stable_cnt_q + SW'(1);
        if (tmo_cnt_q != TW'(LOCK_TIMEOUT))
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        // A qualification completing on the timeout edge wins over the retry.
        if (lock_s_q && (stable_cnt_q >= SW'(LOCK_STABLE - 1))) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          pll_ok_d = 1'b1;
          retry_d  = '0;
        end else if (tmo_cnt_q >= TW'(LOCK_TIMEOUT - 1)) begin
          pll_reset_d = 1'b1;
          rst_cnt_d   = '0;
          retry_d     = retry_inc;
          if (retry_inc >= NW'(MAX_RETRY)) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_RST_PLL;
          end
        end
      end
      ST_IDLE: begin
        if (!lock_s_q) begin
          state_d     = ST_RST_PLL;
          lock_lost_d = 1'b1;
          pll_ok_d    = 1'b0;
          pll_reset_d = 1'b1;
          rst_cnt_d   = '0;
          retry_d     = '0;
        end
      end
      ST_ERROR: begin
        pll_reset_d = 1'b1;
        pll_ok_d    = 1'b0;
        err_d       = 1'b1;
      end
    endcase

    if (accept) begin
      state_d     = ST_RST_PLL;
      idsel_d     = req_idsel;
      fbdsel_d    = req_fbdsel;
      odsel_d     = req_odsel;
      err_d       = 1'b0;
      retry_d     = '0;
      rst_cnt_d   = '0;
      pll_reset_d = 1'b1;
      pll_ok_d    = 1'b0;
      done_d      = 1'b0;
      lock_lost_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= ST_RST_PLL;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      rst_cnt_q    <= '0;
      stable_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      retry_q      <= '0;
      idsel_q      <= DEF_IDSEL;
      fbdsel_q     <= DEF_FBDSEL;
      odsel_q      <= DEF_ODSEL;
      pll_reset_q  <= 1'b1;
      pll_ok_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_meta_q  <= lock_meta_d;
      lock_s_q     <= lock_s_d;
      rst_cnt_q    <= rst_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      retry_q      <= retry_d;
      idsel_q      <= idsel_d;
      fbdsel_q     <= fbdsel_d;
      odsel_q      <= odsel_d;
      pll_reset_q  <= pll_reset_d;
      pll_ok_q     <= pll_ok_d;
      done_q       <= done_d;
      err_q        <= err_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: timed checkpoint table for power-on and a divider
// change, then hand-written retry/error, LOCK glitch, lock-loss and mid-sequence reset cases.
module tb_pll_reconfig_ctrl;

  localparam logic [17:0] DEF_CODES = {6'd12, 6'd40, 6'd2};
  localparam logic [17:0] NEW_CODES = {6'd8, 6'd52, 6'd4};
  localparam logic [17:0] ERR_CODES = {6'd1, 6'd2, 6'd3};
  localparam logic [17:0] GL_CODES  = {6'd5, 6'd6, 6'd7};
  localparam logic [17:0] HLD_CODES = {6'd9, 6'd10, 6'd11};

  // Flag vector order: {pll_reset, pll_ok, done, err, lock_lost, busy, req_ready}
  localparam logic [6:0] F_RST   = 7'b1000010;
  localparam logic [6:0] F_WAIT  = 7'b0000010;
  localparam logic [6:0] F_DONE  = 7'b0110001;
  localparam logic [6:0] F_IDLE  = 7'b0100001;
  localparam logic [6:0] F_ERR   = 7'b1001001;
  localparam logic [6:0] F_LLOST = 7'b1000110;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_idsel, req_fbdsel, req_odsel;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic       pll_ok, busy, done, err, lock_lost;
  logic [6:0] flags;
  logic [17:0] sels;

  assign flags = {pll_reset, pll_ok, done, err, lock_lost, busy, req_ready};
  assign sels  = {pll_idsel, pll_fbdsel, pll_odsel};

  always #5 sys_clk = ~sys_clk;

  pll_reconfig_ctrl #(
    .RST_CYCLES  (4),
    .LOCK_STABLE (8),
    .LOCK_TIMEOUT(50),
    .MAX_RETRY   (2),
    .DEF_IDSEL   (6'd12),
    .DEF_FBDSEL  (6'd40),
    .DEF_ODSEL   (6'd2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_idsel (req_idsel),
    .req_fbdsel(req_fbdsel),
    .req_odsel (req_odsel),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .pll_idsel (pll_idsel),
    .pll_fbdsel(pll_fbdsel),
    .pll_odsel (pll_odsel),
    .pll_ok    (pll_ok),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .lock_lost (lock_lost)
  );

  typedef struct {
    string       name;
    int          n;
    logic        rst_n;
    logic        lock;
    logic        valid;
    logic [17:0] codes;
    logic [6:0]  exp_f;
    logic [17:0] exp_s;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic add(input string nm, input int n, input logic r, input logic l, input logic v,
                     input logic [17:0] c, input logic [6:0] f, input logic [17:0] s);
    vec_t e;
    e.name = nm; e.n = n; e.rst_n = r; e.lock = l; e.valid = v;
    e.codes = c; e.exp_f = f; e.exp_s = s;
    vecs.push_back(e);
  endtask

  task automatic set_req(input logic v, input logic [17:0] c);
    req_valid  = v;
    req_idsel  = c[17:12];
    req_fbdsel = c[11:6];
    req_odsel  = c[5:0];
  endtask

  initial begin
    logic exp_b;

    sys_rst_n = 1'b0;
    pll_lock  = 1'b0;
    set_req(1'b0, '0);

    // Power-on with LOCK 10 cycles after RESET release, then a divider change.
    add("rst_hold",        3, 1'b0, 1'b0, 1'b0, NEW_CODES, F_RST,  DEF_CODES);
    add("por_rst_hi",      3, 1'b1, 1'b0, 1'b0, NEW_CODES, F_RST,  DEF_CODES);
    add("por_rst_fall",    1, 1'b1, 1'b0, 1'b0, NEW_CODES, F_WAIT, DEF_CODES);
    add("por_no_lock",    10, 1'b1, 1'b0, 1'b0, NEW_CODES, F_WAIT, DEF_CODES);
    add("por_qualifying",  9, 1'b1, 1'b1, 1'b0, NEW_CODES, F_WAIT, DEF_CODES);
    add("por_done",        1, 1'b1, 1'b1, 1'b0, NEW_CODES, F_DONE, DEF_CODES);
    add("por_idle",        1, 1'b1, 1'b1, 1'b0, NEW_CODES, F_IDLE, DEF_CODES);
    add("req_accept",      1, 1'b1, 1'b0, 1'b1, NEW_CODES, F_RST,  NEW_CODES);
    add("req_rst_hi",      3, 1'b1, 1'b0, 1'b0, NEW_CODES, F_RST,  NEW_CODES);
    add("req_rst_fall",    1, 1'b1, 1'b0, 1'b0, NEW_CODES, F_WAIT, NEW_CODES);
    add("req_qualifying",  9, 1'b1, 1'b1, 1'b0, NEW_CODES, F_WAIT, NEW_CODES);
    add("req_done",        1, 1'b1, 1'b1, 1'b0, NEW_CODES, F_DONE, NEW_CODES);
    add("req_idle",        1, 1'b1, 1'b1, 1'b0, NEW_CODES, F_IDLE, NEW_CODES);

    foreach (vecs[i]) begin
      sys_rst_n = vecs[i].rst_n;
      pll_lock  = vecs[i].lock;
      set_req(vecs[i].valid, vecs[i].codes);
      for (int c = 0; c < vecs[i].n; c++) tick();
      check({vecs[i].name, "_flags"}, 32'(flags), 32'(vecs[i].exp_f));
      check({vecs[i].name, "_sels"},  32'(sels),  32'(vecs[i].exp_s));
    end
    set_req(1'b0, NEW_CODES);

    // LOCK never rises: two RESET pulses, each followed by a 50-cycle wait, then ERROR.
    pll_lock = 1'b0;
    set_req(1'b1, ERR_CODES);
    for (int k = 0; k <= 110; k++) begin
      tick();
      if (k == 0) begin
        check("err_req_sels", 32'(sels), 32'(ERR_CODES));
        set_req(1'b0, ERR_CODES);
      end
      exp_b = (k <= 3) || (k >= 54 && k <= 57) || (k >= 108);
      check($sformatf("retry_reset_k%0d", k), 32'(pll_reset), 32'(exp_b));
      check($sformatf("retry_err_k%0d", k), 32'(err), 32'(k >= 108));
    end
    check("error_state", 32'(flags), 32'(F_ERR));

    set_req(1'b1, GL_CODES);
    tick();
    check("error_exit_flags", 32'(flags), 32'(F_RST));
    check("error_exit_sels", 32'(sels), 32'(GL_CODES));
    set_req(1'b0, GL_CODES);

    // LOCK toggling with period 6 never qualifies; timeout retries, then held LOCK qualifies.
    for (int k = 1; k <= 70; k++) begin
      tick();
      exp_b = (k <= 3) || (k >= 54 && k <= 57);
      check($sformatf("glitch_reset_k%0d", k), 32'(pll_reset), 32'(exp_b));
      check($sformatf("glitch_done_k%0d", k), 32'(done), 32'(k == 70));
      if (k < 50)       pll_lock = ((k / 3) % 2) == 1;
      else if (k >= 60) pll_lock = 1'b1;
      else              pll_lock = 1'b0;
    end
    check("glitch_ok", 32'(pll_ok), 32'd1);
    check("glitch_err", 32'(err), 32'd0);

    // LOCK loss in IDLE coinciding with a request: lock-loss path first, request held.
    pll_lock = 1'b0;
    tick();
    tick();
    check("drop_ready_low", 32'(req_ready), 32'd0);
    check("drop_ok_still", 32'(pll_ok), 32'd1);
    set_req(1'b1, HLD_CODES);
    tick();
    check("drop_lock_lost", 32'(flags), 32'(F_LLOST));
    check("drop_old_sels", 32'(sels), 32'(GL_CODES));
    for (int c = 0; c < 4; c++) tick();
    check("drop_rst_fall", 32'(flags), 32'(F_WAIT));
    pll_lock = 1'b1;
    for (int c = 0; c < 9; c++) tick();
    check("drop_relock_wait", 32'(flags), 32'(F_WAIT));
    check("drop_relock_sels", 32'(sels), 32'(GL_CODES));
    tick();
    check("drop_relock_done", 32'(flags), 32'(F_DONE));
    tick();
    check("held_req_flags", 32'(flags), 32'(F_RST));
    check("held_req_sels", 32'(sels), 32'(HLD_CODES));
    set_req(1'b0, HLD_CODES);

    // Reset asserted mid-WAIT_LOCK restores reset values and restarts power-on.
    for (int c = 0; c < 6; c++) tick();
    check("mid_wait_flags", 32'(flags), 32'(F_WAIT));
    sys_rst_n = 1'b0;
    pll_lock  = 1'b0;
    tick();
    check("mid_rst_flags", 32'(flags), 32'(F_RST));
    check("mid_rst_sels", 32'(sels), 32'(DEF_CODES));
    tick();
    sys_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    check("restart_rst_hi", 32'(flags), 32'(F_RST));
    tick();
    check("restart_rst_fall", 32'(flags), 32'(F_WAIT));
    check("restart_sels", 32'(sels), 32'(DEF_CODES));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
